// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: March-style RAM self-test controller.
//   Runs four phases over the whole address space:
//     P0 ascending  write PAT
//     P1 ascending  read/compare PAT,  write ~PAT
//     P2 descending read/compare ~PAT, write PAT
//     P3 ascending  read/compare PAT
//   Stops at the first mismatch and records its address and read data.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                level request, sampled only in IDLE
//   mem_rdata            RAM read data, valid the cycle after mem_read
//   mem_wdata, mem_add   RAM write data and address (hold when idle)
//   mem_read, mem_write  RAM strobes; mem_en = mem_read | mem_write
//   busy, done           test running / one-cycle completion pulse
//   pass, fail           sticky result of the last test
//   fail_add, fail_data  address and data of the first mismatch
module ram_bist_ctrl #(
    parameter int unsigned       ADDR_W = 6,
    parameter int unsigned       DATA_W = 16,
    parameter logic [DATA_W-1:0] PAT    = DATA_W'(16'h5555)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_add,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_add,
    output logic [DATA_W-1:0] fail_data
);

    localparam logic [ADDR_W-1:0] ADDR_FIRST = '0;
    localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR0  = 3'd1,
        S_RD   = 3'd2,
        S_CMP  = 3'd3,
        S_WR   = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              pass_d, fail_d;
    logic [ADDR_W-1:0] fail_add_d;
    logic [DATA_W-1:0] fail_data_d;
    logic [DATA_W-1:0] expect_c;
    logic              mismatch_c;

    // Only P2 reads back the complement pattern
    assign expect_c   = (phase_q == P2) ? ~PAT : PAT;
    assign mismatch_c = (mem_rdata != expect_c);

    // Next-state, address sequencing and result capture
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        addr_d      = mem_add;
        wdata_d     = mem_wdata;
        pass_d      = pass;
        fail_d      = fail;
        fail_add_d  = fail_add;
        fail_data_d = fail_data;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WR0;
                    phase_d     = P0;
                    addr_d      = ADDR_FIRST;
                    wdata_d     = PAT;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_add_d  = '0;
                    fail_data_d = '0;
                end
            end
            S_WR0: begin
                if (mem_add == ADDR_LAST) begin
                    state_d = S_RD;
                    phase_d = P1;
                    addr_d  = ADDR_FIRST;
                end else begin
                    addr_d = mem_add + ADDR_W'(1);
                end
            end
            S_RD: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                if (mismatch_c) begin
                    state_d     = S_FIN;
                    fail_d      = 1'b1;
                    fail_add_d  = mem_add;
                    fail_data_d = mem_rdata;
                end else if (phase_q == P3) begin
                    if (mem_add == ADDR_LAST) begin
                        state_d = S_FIN;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_RD;
                        addr_d  = mem_add + ADDR_W'(1);
                    end
                end else begin
                    state_d = S_WR;
                    wdata_d = (phase_q == P1) ? ~PAT : PAT;
                end
            end
            S_WR: begin
                state_d = S_RD;
                // Phase turnarounds keep the end address as the next start
                if (phase_q == P1) begin
                    if (mem_add == ADDR_LAST) phase_d = P2;
                    else                      addr_d  = mem_add + ADDR_W'(1);
                end else begin
                    if (mem_add == ADDR_FIRST) phase_d = P3;
                    else                       addr_d  = mem_add - ADDR_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; outputs are registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= P0;
            mem_add   <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_add  <= '0;
            fail_data <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            mem_add   <= addr_d;
            mem_wdata <= wdata_d;
            mem_read  <= (state_d == S_RD);
            mem_write <= (state_d == S_WR0) || (state_d == S_WR);
            mem_en    <= (state_d == S_RD) || (state_d == S_WR0) || (state_d == S_WR);
            busy      <= (state_d == S_WR0) || (state_d == S_RD) ||
                         (state_d == S_CMP) || (state_d == S_WR);
            done      <= (state_d == S_FIN);
            pass      <= pass_d;
            fail      <= fail_d;
            fail_add  <= fail_add_d;
            fail_data <= fail_data_d;
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: directed bench for ram_bist_ctrl with a 64x16 RAM model
// and an optional bit0 stuck-at-1 cell at address 10.
module tb_ram_bist_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] mem_rdata;
    logic [15:0] mem_wdata;
    logic [5:0]  mem_add;
    logic        mem_read;
    logic        mem_write;
    logic        mem_en;
    logic        busy;
    logic        done;
    logic        pass;
    logic        fail;
    logic [5:0]  fail_add;
    logic [15:0] fail_data;

    ram_bist_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_add   (mem_add),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_en    (mem_en),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .fail_add  (fail_add),
        .fail_data (fail_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write and registered read; optional stuck bit
    logic [15:0] ram [64];
    logic        stuck;
    always @(posedge clk) begin
        if (mem_en && mem_write) ram[mem_add] <= mem_wdata;
        if (mem_en && mem_read)
            mem_rdata <= (stuck && mem_add == 6'd10) ? (ram[mem_add] | 16'h0001) : ram[mem_add];
    end

    // Activity counters, sampled at the rising edge for the ending cycle
    int cyc, busy_cnt, wr_cnt, rd_cnt, done_cnt, post_fail_strobes, en_err;
    initial begin
        cyc = 0; busy_cnt = 0; wr_cnt = 0; rd_cnt = 0;
        done_cnt = 0; post_fail_strobes = 0; en_err = 0;
    end
    always @(posedge clk) begin
        cyc++;
        if (busy)      busy_cnt++;
        if (mem_write) wr_cnt++;
        if (mem_read)  rd_cnt++;
        if (done)      done_cnt++;
        if (fail && (mem_read || mem_write)) post_fail_strobes++;
        if (mem_en !== (mem_read | mem_write)) en_err++;
    end

    logic [50:0] all_out;
    assign all_out = {mem_wdata, mem_add, mem_read, mem_write, mem_en, busy,
                      done, pass, fail, fail_add, fail_data};

    int nchk, nerr;
    int b0, w0, r0, d0, c1, c2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        nchk = 0; nerr = 0;
        rst_n = 1'b0; start = 1'b0; stuck = 1'b0;

        // Reset: everything zero, and stays idle with start low
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(all_out), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_reset", 64'(all_out), 64'd0);

        // Fault-free run
        b0 = busy_cnt; w0 = wr_cnt; r0 = rd_cnt;
        pulse_start();
        check("first_write", 64'({mem_write, mem_read, busy}), 64'b101);
        check("first_add", 64'(mem_add), 64'd0);
        check("first_wdata", 64'(mem_wdata), 64'h5555);
        wait_done("run1_done", 700);
        check("run1_busy_cycles", 64'(busy_cnt - b0), 64'd576);
        check("run1_busy_low_at_done", 64'(busy), 64'd0);
        check("run1_pass_fail", 64'({pass, fail}), 64'b10);
        check("run1_writes", 64'(wr_cnt - w0), 64'd192);
        check("run1_reads", 64'(rd_cnt - r0), 64'd192);
        @(negedge clk);
        check("run1_done_one_cycle", 64'(done), 64'd0);
        check("run1_pass_held", 64'(pass), 64'd1);

        // Stuck-at-1 on bit0 at address 10: caught in descending phase
        stuck = 1'b1;
        b0 = busy_cnt;
        pulse_start();
        check("run2_pass_cleared", 64'({pass, fail}), 64'b00);
        wait_done("run2_done", 700);
        check("run2_busy_cycles", 64'(busy_cnt - b0), 64'd417);
        check("run2_pass_fail", 64'({pass, fail}), 64'b01);
        check("run2_fail_add", 64'(fail_add), 64'd10);
        check("run2_fail_data", 64'(fail_data), 64'hAAAB);
        check("run2_strobes_at_done", 64'({mem_read, mem_write, mem_en}), 64'd0);
        repeat (5) @(negedge clk);
        check("run2_no_strobes_after", 64'(post_fail_strobes), 64'd0);
        check("run2_busy_stays_low", 64'(busy_cnt - b0), 64'd417);
        check("run2_fail_held", 64'({fail, fail_add, fail_data}), {1'b1, 6'd10, 16'hAAAB});
        stuck = 1'b0;

        // start pulsed again at busy cycle 50 is ignored
        b0 = busy_cnt; d0 = done_cnt;
        pulse_start();
        repeat (49) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("run3_done", 700);
        check("run3_busy_cycles", 64'(busy_cnt - b0), 64'd576);
        check("run3_pass_fail", 64'({pass, fail, fail_add, fail_data}), {1'b1, 1'b0, 22'd0});
        repeat (3) @(negedge clk);
        check("run3_single_done", 64'(done_cnt - d0), 64'd1);

        // Reset at busy cycle 100 aborts with no done pulse
        d0 = done_cnt;
        pulse_start();
        repeat (99) @(negedge clk);
        check("run4_busy_before_abort", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs_zero", 64'(all_out), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_idle", 64'(all_out), 64'd0);
        b0 = busy_cnt;
        pulse_start();
        wait_done("run5_done", 700);
        check("run5_busy_cycles", 64'(busy_cnt - b0), 64'd576);
        check("run5_pass", 64'({pass, fail}), 64'b10);

        // start held high: back-to-back runs every 578 cycles
        @(negedge clk);
        start = 1'b1;
        wait_done("run6a_done", 700);
        c1 = cyc;
        check("run6a_pass", 64'(pass), 64'd1);
        @(negedge clk);
        check("run6_idle_gap", 64'({busy, pass}), 64'b01);
        @(negedge clk);
        check("run6b_restart", 64'({busy, mem_write, pass, fail}), 64'b1100);
        wait_done("run6b_done", 700);
        c2 = cyc;
        start = 1'b0;
        check("run6_period", 64'(c2 - c1), 64'd578);
        @(negedge clk);
        check("run6b_done_one_cycle", 64'(done), 64'd0);
        check("mem_en_consistent", 64'(en_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ram_bist_ctrl.md
RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 6, address width (64 words).
- DATA_W, 16, word width.
- PAT, 16'h5555, background pattern; its complement ~PAT is the second pattern.

REQ-002 Ports SHALL be, in this order:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE.
- mem_rdata  in  DATA_W  RAM read data; valid one cycle after mem_read is asserted.
- mem_wdata  out  DATA_W  RAM write data.
- mem_add  out  ADDR_W  RAM address.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe; the RAM writes on the clk edge while mem_write=1 and mem_en=1.
- mem_en  out  1  RAM enable; equals mem_read OR mem_write.
- busy  out  1  test in progress.
- done  out  1  one-cycle completion pulse.
- pass  out  1  sticky; last test found no mismatch.
- fail  out  1  sticky; last test found a mismatch.
- fail_add  out  ADDR_W  address of the first mismatch.
- fail_data  out  DATA_W  data read at the first mismatch.

REQ-003 The block SHALL have one clock (clk) and an asynchronous, active-low reset (rst_n).

Function
REQ-004 The FSM SHALL have the states IDLE, WR0, RD, CMP, WR and FIN, plus a 2-bit phase register (P0..P3) and an ADDR_W-bit address counter.
REQ-005 IDLE, start=1 -> WR0 with phase P0 and address 0; start is ignored in every other state.
REQ-006 P0, ascending 0..63: WR0 drives mem_write=1 and mem_wdata=PAT, one address per cycle; after address 63 -> RD with phase P1 and address 0.
REQ-007 P1, ascending: RD (mem_read=1) -> CMP (compare with PAT) -> WR (write ~PAT), 3 cycles per address.
REQ-008 P2, descending 63..0: RD -> CMP (compare with ~PAT) -> WR (write PAT), 3 cycles per address.
REQ-009 P3, ascending: RD -> CMP (compare with PAT), 2 cycles per address; after CMP at address 63 with no mismatch -> FIN.
REQ-010 In CMP, mem_rdata SHALL be sampled; all memory strobes SHALL be 0 in CMP.
REQ-011 First mismatch in CMP: capture fail_add=mem_add and fail_data=mem_rdata, set fail=1, go directly to FIN; no further memory accesses occur.
REQ-012 FIN SHALL last one cycle with done=1 and busy=0, then go to IDLE; pass=1 only if no mismatch occurred.
REQ-013 busy=1 in WR0, RD, CMP and WR; a fault-free run holds busy=1 for exactly 576 cycles (64 + 192 + 192 + 128).
REQ-014 Address counter end conditions: ascending phases end at 63; the descending phase ends at 0; no wrap-around access is ever issued.
REQ-015 pass, fail, fail_add and fail_data SHALL hold until the next accepted start, which clears all four on the WR0 entry edge.
REQ-016 All outputs SHALL be driven from registered state only, with no combinational path from any input to any output.
REQ-017 Outside RD, WR0 and WR, mem_read, mem_write and mem_en SHALL be 0, and mem_add and mem_wdata SHALL hold their last value.
REQ-018 If start is held high continuously, a new test SHALL begin on the cycle after FIN.

Reset
REQ-019 rst_n=0 SHALL immediately force IDLE and set every output to 0 (mem_*, busy, done, pass, fail, fail_add, fail_data), including mid-test; no done pulse is issued for an aborted test.
REQ-020 After rst_n rises, the block SHALL stay in IDLE until start is sampled high.

Verification
REQ-021 Reset check: assert rst_n=0 -> every output is 0 and stays 0 with start=0.
REQ-022 Fault-free 64x16 RAM model plus a one-cycle start pulse -> the first cycle shows mem_write=1, mem_add=0, mem_wdata=16'h5555:
- busy=1 for 576 cycles, then done=1 for exactly one cycle.
- pass=1 and fail=0.
- 192 write cycles and 192 read cycles in total.
REQ-023 Model with bit0 stuck-at-1 at address 10 -> P1 passes and the mismatch occurs in P2 (descending):
- fail=1, pass=0, fail_add=10, fail_data=16'hAAAB.
- done follows the failing CMP by one cycle.
- No memory strobe occurs after that CMP.
REQ-024 start pulsed again at busy cycle 50 -> ignored; the run still completes in 576 cycles.
REQ-025 rst_n pulsed low at busy cycle 100 -> outputs are 0 immediately and no done pulse occurs; a subsequent start runs a full 576-cycle pass.
REQ-026 start held high -> done pulses every 578 cycles (576 busy + FIN + IDLE); pass and fail are cleared at each new WR0 entry.
